// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared types for the trace debug encoder blocks
package trdb_pkg;

  // Encoder session state as seen by the packet-priority stage.
  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAIT_QUAL = 2'd1,
    TRACING   = 2'd2
  } enc_state_e;

  // What advances the resync timer.
  typedef enum logic {
    RESYNC_CYCLES  = 1'b0,
    RESYNC_PACKETS = 1'b1
  } resync_mode_e;

  // True while the encoder is switched on, whether or not a window is open.
  function automatic logic enc_is_on(enc_state_e st);
    return st != OFF;
  endfunction

endpackage

// File: rtl/trdb_resync_counter.sv
// rtl/trdb_resync_counter.sv - saturating resync timer with threshold compare
module trdb_resync_counter #(
  parameter int unsigned RESYNC_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                inc_i,
  input  logic [RESYNC_W-1:0] max_i,
  output logic                gt_o,
  output logic                et_o
);

  localparam logic [RESYNC_W-1:0] CntOne = {{(RESYNC_W-1){1'b0}}, 1'b1};
  localparam logic [RESYNC_W-1:0] CntSat = {RESYNC_W{1'b1}};

  logic [RESYNC_W-1:0] cnt_q;
  logic                max_zero;

  // Clear has priority over increment; the count sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CntSat)) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  // Threshold flags follow the register directly; a zero threshold disables resync.
  always_comb begin
    max_zero = (max_i == '0);
    gt_o     = !max_zero && (cnt_q >= max_i);
    et_o     = !max_zero && (cnt_q == (max_i - CntOne));
  end

endmodule

// File: rtl/trdb_trace_ctrl.sv
// rtl/trdb_trace_ctrl.sv - trace-session controller: enable, qualification window, resync timer
module trdb_trace_ctrl
  import trdb_pkg::*;
#(
  parameter int unsigned RESYNC_W = 16,
  parameter int unsigned OPMODE_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                valid_i,
  input  logic                qualified_i,
  input  logic [OPMODE_W-1:0] opmode_i,
  input  logic                resync_mode_i,
  input  logic [RESYNC_W-1:0] max_resync_i,
  input  logic                packet_emitted_i,
  input  logic                resync_rst_i,
  output logic                tc_enc_enabled_o,
  output logic                tc_enc_disabled_o,
  output logic                tc_first_qualified_o,
  output logic                lc_final_qualified_o,
  output logic                tc_opmode_change_o,
  output logic                tc_gt_max_resync_o,
  output logic                tc_et_max_resync_o,
  output logic [1:0]          state_o
);

  enc_state_e          state_q, state_d;
  logic [OPMODE_W-1:0] opmode_q;

  logic enabled_ev, disabled_ev, final_ev, opmode_ev, first_qual;
  logic enabled_q, disabled_q, final_q, opmode_chg_q;
  logic cnt_clear, cnt_inc;

  // Session state register; reset drops straight to OFF without emitting any pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: losing enable beats a qualified retirement in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: begin
        if (enable_i) state_d = WAIT_QUAL;
      end
      WAIT_QUAL: begin
        if (!enable_i)                    state_d = OFF;
        else if (valid_i && qualified_i)  state_d = TRACING;
      end
      TRACING: begin
        if (!enable_i)                    state_d = OFF;
        else if (valid_i && !qualified_i) state_d = WAIT_QUAL;
      end
      default: state_d = OFF;
    endcase
  end

  // Session events derived from the transition, plus resync timer controls.
  always_comb begin
    first_qual  = (state_q == WAIT_QUAL) && (state_d == TRACING);
    enabled_ev  = !enc_is_on(state_q) && enc_is_on(state_d);
    disabled_ev = enc_is_on(state_q) && !enc_is_on(state_d);
    final_ev    = (state_q == TRACING) && (state_d != TRACING);
    // Next-state based so an opmode write landing with enable still reports.
    opmode_ev   = (opmode_i != opmode_q) && enc_is_on(state_d);
    cnt_clear   = (state_d != TRACING) || resync_rst_i;
    cnt_inc     = (resync_mode_e'(resync_mode_i) == RESYNC_PACKETS) ? packet_emitted_i : 1'b1;
  end

  // One-cycle registered strobes for the priority stage, and the opmode history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enabled_q    <= 1'b0;
      disabled_q   <= 1'b0;
      final_q      <= 1'b0;
      opmode_chg_q <= 1'b0;
      opmode_q     <= '0;
    end else begin
      enabled_q    <= enabled_ev;
      disabled_q   <= disabled_ev;
      final_q      <= final_ev;
      opmode_chg_q <= opmode_ev;
      opmode_q     <= opmode_i;
    end
  end

  trdb_resync_counter #(
    .RESYNC_W (RESYNC_W)
  ) u_resync_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .max_i   (max_resync_i),
    .gt_o    (tc_gt_max_resync_o),
    .et_o    (tc_et_max_resync_o)
  );

  assign tc_enc_enabled_o     = enabled_q;
  assign tc_enc_disabled_o    = disabled_q;
  assign lc_final_qualified_o = final_q;
  assign tc_opmode_change_o   = opmode_chg_q;
  // First qualification is flagged alongside the instruction that opens the window.
  assign tc_first_qualified_o = first_qual;
  assign state_o              = state_q;

endmodule
